trace_record_buffer: RTL

Elastic buffer directly downstream of `trace_unit`. It captures every record the trace unit emits on its `trace_data_ready` pulse, tags each offered record with a sequence number, and presents records to a consumer (trace port, DMA or debug memory) over a valid/ready handshake. The buffer absorbs bursts while the consumer stalls. It counts records dropped on overflow, and sequence-number gaps let software locate those losses.

---
 rtl/trace_record_buffer_if.sv | 38 +++
 rtl/trace_record_buffer.sv | 113 +++++++++++
 2 files changed

// File: rtl/trace_record_buffer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trace_record_buffer_if : producer/consumer/status bundle of trace_record_buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
interface trace_record_buffer_if #(
   parameter int DEPTH       = 16,
   parameter int SEQ_WIDTH   = 16,
   parameter int DROP_WIDTH  = 16,
   parameter int TRACE_WIDTH = 32
);
   localparam int OCC_WIDTH = $clog2(DEPTH) + 1;

   logic                   trace_data_ready;
   logic [TRACE_WIDTH-1:0] trace_data_i;
   logic                   out_valid;
   logic                   out_ready;
   logic [TRACE_WIDTH-1:0] out_data;
   logic [SEQ_WIDTH-1:0]   out_seq;
   logic [OCC_WIDTH-1:0]   occupancy;
   logic                   almost_full;
   logic                   overflow;
   logic [DROP_WIDTH-1:0]  drop_count;
   logic                   clear_overflow;

   // Buffer side.
   modport slave (
      input  trace_data_ready, trace_data_i, out_ready, clear_overflow,
      output out_valid, out_data, out_seq, occupancy, almost_full, overflow, drop_count
   );

   // Trace unit / consumer side.
   modport master (
      output trace_data_ready, trace_data_i, out_ready, clear_overflow,
      input  out_valid, out_data, out_seq, occupancy, almost_full, overflow, drop_count
   );
endinterface
`default_nettype wire

// File: rtl/trace_record_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trace_record_buffer : FWFT elastic buffer tagging trace records with sequence numbers
// Revision: 1.0
// ---------------------------------------------------------------------------
module trace_record_buffer #(
   parameter int DEPTH       = 16,
   parameter int AF_LEVEL    = 12,
   parameter int SEQ_WIDTH   = 16,
   parameter int DROP_WIDTH  = 16,
   parameter int TRACE_WIDTH = 32
) (
   input  wire logic               clk,
   input  wire logic               rst,
   trace_record_buffer_if.slave    bus
);
   localparam int PTR_WIDTH = $clog2(DEPTH);
   localparam int OCC_WIDTH = PTR_WIDTH + 1;
   localparam int REC_WIDTH = TRACE_WIDTH + SEQ_WIDTH;

   localparam logic [OCC_WIDTH-1:0]  c_full     = OCC_WIDTH'(DEPTH);
   localparam logic [OCC_WIDTH-1:0]  c_af_level = OCC_WIDTH'(AF_LEVEL);
   localparam logic [DROP_WIDTH-1:0] c_drop_max = '1;
   localparam logic [DROP_WIDTH-1:0] c_drop_one = DROP_WIDTH'(1);

   logic [REC_WIDTH-1:0]  mem_q [DEPTH];

   logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [OCC_WIDTH-1:0]  occ_q, occ_d;
   logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
   logic                  overflow_q, overflow_d;
   logic [DROP_WIDTH-1:0] drop_q, drop_d;

   logic                  w_empty;
   logic                  w_offer;
   logic                  w_pop;
   logic                  w_accept;
   logic                  w_drop;
   logic [REC_WIDTH-1:0]  w_head;

   always_comb begin
      w_empty  = (occ_q == '0);
      w_offer  = bus.trace_data_ready;
      // A pop in the same cycle frees the head slot, so a full buffer still accepts.
      w_pop    = !w_empty && bus.out_ready;
      w_accept = w_offer && ((occ_q < c_full) || w_pop);
      w_drop   = w_offer && !w_accept;

      wr_ptr_d = w_accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = w_pop    ? rd_ptr_q + 1'b1 : rd_ptr_q;
      seq_d    = w_offer  ? seq_q + 1'b1    : seq_q;

      occ_d = occ_q;
      case ({w_accept, w_pop})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase

      // A drop in the clear cycle is the first drop of the new epoch.
      overflow_d = overflow_q;
      drop_d     = drop_q;
      if (w_drop) begin
         overflow_d = 1'b1;
         if (bus.clear_overflow) begin
            drop_d = c_drop_one;
         end else if (drop_q != c_drop_max) begin
            drop_d = drop_q + 1'b1;
         end
      end else if (bus.clear_overflow) begin
         overflow_d = 1'b0;
         drop_d     = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         seq_q      <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         seq_q      <= seq_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
      end
   end

   // Record storage carries no reset so it can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         mem_q[wr_ptr_q] <= {bus.trace_data_i, seq_q};
      end
   end

   assign w_head = mem_q[rd_ptr_q];

   assign bus.out_valid   = !w_empty;
   assign bus.out_data    = w_empty ? '0 : w_head[REC_WIDTH-1:SEQ_WIDTH];
   assign bus.out_seq     = w_empty ? '0 : w_head[SEQ_WIDTH-1:0];
   assign bus.occupancy   = occ_q;
   assign bus.almost_full = (occ_q >= c_af_level);
   assign bus.overflow    = overflow_q;
   assign bus.drop_count  = drop_q;

endmodule
`default_nettype wire
